// File: rtl/game_pkg.sv
// Shared definitions for the word-scramble game: FSM state encoding,
// datapath widths and default game parameters.
package game_pkg;

    localparam int ADDR_W = 6;
    localparam int WORD_W = 4;
    localparam int MODE_W = 2;

    localparam int ROUNDS_DEF     = 8;
    localparam int LIVES_DEF      = 3;
    localparam int TIME_LIMIT_DEF = 30;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        ROM_WAIT = 3'd2,
        SCRAMBLE = 3'd3,
        PLAY     = 3'd4,
        JUDGE    = 3'd5,
        NEXT     = 3'd6,
        OVER     = 3'd7
    } state_t;

endpackage

// File: rtl/round_timer.sv
// Per-round countdown: loads the time limit, counts down on each accepted
// second tick, and flags the last remaining second.
module round_timer #(
    parameter int TIME_LIMIT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       dec,
    output logic [5:0] time_left,
    output logic       expired
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            time_left <= '0;
        end else if (load) begin
            time_left <= 6'(TIME_LIMIT);
        end else if (dec && time_left != 6'd0) begin
            time_left <= time_left - 6'd1;
        end
    end

    // One second left: the next accepted tick ends the round.
    assign expired = (time_left == 6'd1);

endmodule

// File: rtl/round_sequencer.sv
// Game-level round controller: picks the word, launches the scrambler,
// times the player's attempt, and keeps score, lives and round count.
module round_sequencer
    import game_pkg::*;
#(
    parameter int ROUNDS     = ROUNDS_DEF,
    parameter int LIVES      = LIVES_DEF,
    parameter int TIME_LIMIT = TIME_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              submit,
    input  logic              sec_tick,
    input  logic [MODE_W-1:0] mode,
    input  logic [WORD_W-1:0] rng_addr,
    input  logic              isCorrect,
    input  logic              scr_done,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              scr_start,
    output logic              en,
    output logic [3:0]        round,
    output logic [3:0]        score,
    output logic [2:0]        lives,
    output logic [5:0]        time_left,
    output logic              game_over
);

    state_t            state;
    logic [MODE_W-1:0] mode_q;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_next;
    logic              correct_q;
    logic              timer_load;
    logic              timer_dec;
    logic              expired;

    // Never repeat the previous round's word back-to-back.
    assign word_next = (rng_addr == word_q) ? rng_addr + 4'd1 : rng_addr;

    // scr_start high marks the first SCRAMBLE cycle, where scr_done is ignored.
    assign timer_load = (state == SCRAMBLE) && !scr_start && scr_done;
    assign timer_dec  = (state == PLAY) && sec_tick && !submit;

    assign rom_addr = {mode_q, word_q};

    round_timer #(
        .TIME_LIMIT(TIME_LIMIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .dec      (timer_dec),
        .time_left(time_left),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            scr_start <= 1'b0;
            en        <= 1'b0;
            game_over <= 1'b0;
            round     <= 4'd0;
            score     <= 4'd0;
            lives     <= 3'(LIVES);
            mode_q    <= '0;
            word_q    <= '0;
            correct_q <= 1'b0;
        end else begin
            scr_start <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        round     <= 4'd1;
                        score     <= 4'd0;
                        lives     <= 3'(LIVES);
                        mode_q    <= mode;
                        game_over <= 1'b0;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    word_q <= word_next;
                    state  <= ROM_WAIT;
                end
                ROM_WAIT: begin
                    scr_start <= 1'b1;
                    state     <= SCRAMBLE;
                end
                SCRAMBLE: begin
                    if (!scr_start && scr_done) begin
                        en    <= 1'b1;
                        state <= PLAY;
                    end
                end
                PLAY: begin
                    // Submit outranks a final tick arriving in the same cycle.
                    if (submit) begin
                        correct_q <= isCorrect;
                        en        <= 1'b0;
                        state     <= JUDGE;
                    end else if (sec_tick && expired) begin
                        correct_q <= 1'b0;
                        en        <= 1'b0;
                        state     <= JUDGE;
                    end
                end
                JUDGE: begin
                    if (correct_q) begin
                        if (score != 4'd15) begin
                            score <= score + 4'd1;
                        end
                    end else if (lives != 3'd0) begin
                        lives <= lives - 3'd1;
                    end
                    state <= NEXT;
                end
                NEXT: begin
                    if (lives == 3'd0 || round == 4'(ROUNDS)) begin
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        round <= round + 4'd1;
                        state <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
